// File: rtl/wb_port_arbiter.sv
// Merges dual-issue writeback and a 2-entry buffer of long-latency results onto
// the two register-file write ports; raises stall_o when a buffered result starves.
module wb_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int WAIT_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pri_we_i,
   input  logic [4:0]        pri_waddr_i,
   input  logic [DATA_W-1:0] pri_wdata_i,
   input  logic              sec_we_i,
   input  logic [4:0]        sec_waddr_i,
   input  logic [DATA_W-1:0] sec_wdata_i,
   input  logic              late_valid_i,
   input  logic [4:0]        late_waddr_i,
   input  logic [DATA_W-1:0] late_wdata_i,
   output logic              late_ready_o,
   output logic              rf_we0_o,
   output logic [4:0]        rf_waddr0_o,
   output logic [DATA_W-1:0] rf_wdata0_o,
   output logic              rf_we1_o,
   output logic [4:0]        rf_waddr1_o,
   output logic [DATA_W-1:0] rf_wdata1_o,
   output logic [1:0]        late_commit_o,
   output logic              stall_o
);

   // slot 0 is always the head; slot 1 is only valid when slot 0 is valid
   logic [1:0]        v_q, k_q;
   logic [4:0]        a_q [2];
   logic [DATA_W-1:0] d_q [2];
   logic [3:0]        cnt_q;
   logic              stall_q;

   logic              pri_eff, sec_eff, pri_sup, p0_busy, p1_busy, enq;
   logic [1:0]        kill_now;
   logic [1:0]        h_port, s_port;
   logic              pop0, pop1;

   logic [1:0]        v_n, k_n;
   logic [4:0]        a_n [2];
   logic [DATA_W-1:0] d_n [2];
   logic [3:0]        cnt_d;
   logic              stall_d;

   assign pri_eff      = pri_we_i && (pri_waddr_i != 5'd0);
   assign sec_eff      = sec_we_i && (sec_waddr_i != 5'd0);
   assign pri_sup      = pri_eff && sec_eff && (pri_waddr_i == sec_waddr_i);
   assign p0_busy      = pri_eff && !pri_sup;
   assign p1_busy      = sec_eff;
   assign late_ready_o = !(v_q[0] && v_q[1]);
   assign enq          = late_valid_i && late_ready_o;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         kill_now[i] = v_q[i] && (k_q[i] ||
                       (pri_eff && (pri_waddr_i == a_q[i])) ||
                       (sec_eff && (sec_waddr_i == a_q[i])) ||
                       (enq && (late_waddr_i == a_q[i])));
      end
   end

   // in-order allocation: the second entry may only leave if the head leaves
   always_comb begin
      h_port = 2'b00;
      s_port = 2'b00;
      pop0   = 1'b0;
      pop1   = 1'b0;
      if (v_q[0]) begin
         if (kill_now[0]) begin
            pop0 = 1'b1;
         end else if (!p0_busy) begin
            h_port = 2'b01;
            pop0   = 1'b1;
         end else if (!p1_busy) begin
            h_port = 2'b10;
            pop0   = 1'b1;
         end
      end
      if (pop0 && v_q[1]) begin
         if (kill_now[1]) begin
            pop1 = 1'b1;
         end else if (!p0_busy && !h_port[0]) begin
            s_port = 2'b01;
            pop1   = 1'b1;
         end else if (!p1_busy && !h_port[1]) begin
            s_port = 2'b10;
            pop1   = 1'b1;
         end
      end
   end

   always_comb begin
      rf_we0_o    = 1'b0;
      rf_waddr0_o = '0;
      rf_wdata0_o = '0;
      rf_we1_o    = 1'b0;
      rf_waddr1_o = '0;
      rf_wdata1_o = '0;
      late_commit_o = 2'b00;
      if (rst) begin
         late_commit_o = h_port | s_port;
         if (p0_busy) begin
            rf_we0_o = 1'b1; rf_waddr0_o = pri_waddr_i; rf_wdata0_o = pri_wdata_i;
         end else if (h_port[0]) begin
            rf_we0_o = 1'b1; rf_waddr0_o = a_q[0]; rf_wdata0_o = d_q[0];
         end else if (s_port[0]) begin
            rf_we0_o = 1'b1; rf_waddr0_o = a_q[1]; rf_wdata0_o = d_q[1];
         end
         if (p1_busy) begin
            rf_we1_o = 1'b1; rf_waddr1_o = sec_waddr_i; rf_wdata1_o = sec_wdata_i;
         end else if (h_port[1]) begin
            rf_we1_o = 1'b1; rf_waddr1_o = a_q[0]; rf_wdata1_o = d_q[0];
         end else if (s_port[1]) begin
            rf_we1_o = 1'b1; rf_waddr1_o = a_q[1]; rf_wdata1_o = d_q[1];
         end
      end
   end

   always_comb begin
      v_n = v_q;
      k_n = kill_now;
      a_n = a_q;
      d_n = d_q;
      if (pop0 && pop1) begin
         v_n = 2'b00;
      end else if (pop0) begin
         v_n    = {1'b0, v_q[1]};
         k_n    = {1'b0, kill_now[1]};
         a_n[0] = a_q[1];
         d_n[0] = d_q[1];
      end
      // a zero-destination result is accepted but never stored
      if (enq && (late_waddr_i != 5'd0)) begin
         if (!v_n[0]) begin
            v_n[0] = 1'b1; k_n[0] = 1'b0; a_n[0] = late_waddr_i; d_n[0] = late_wdata_i;
         end else begin
            v_n[1] = 1'b1; k_n[1] = 1'b0; a_n[1] = late_waddr_i; d_n[1] = late_wdata_i;
         end
      end
      if (!v_q[0] || pop0) begin
         cnt_d   = 4'd0;
         stall_d = 1'b0;
      end else begin
         cnt_d   = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
         stall_d = stall_q || (cnt_q >= 4'(WAIT_LIMIT));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q     <= 2'b00;
         k_q     <= 2'b00;
         a_q[0]  <= '0;
         a_q[1]  <= '0;
         d_q[0]  <= '0;
         d_q[1]  <= '0;
         cnt_q   <= 4'd0;
         stall_q <= 1'b0;
      end else begin
         v_q     <= v_n;
         k_q     <= k_n;
         a_q[0]  <= a_n[0];
         a_q[1]  <= a_n[1];
         d_q[0]  <= d_n[0];
         d_q[1]  <= d_n[1];
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign stall_o = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: port mapping, late fill-in, kills,
// backpressure, starvation stall and asynchronous reset.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pri_we_i, sec_we_i, late_valid_i;
   logic [4:0]  pri_waddr_i, sec_waddr_i, late_waddr_i;
   logic [31:0] pri_wdata_i, sec_wdata_i, late_wdata_i;
   logic        late_ready_o, rf_we0_o, rf_we1_o, stall_o;
   logic [4:0]  rf_waddr0_o, rf_waddr1_o;
   logic [31:0] rf_wdata0_o, rf_wdata1_o;
   logic [1:0]  late_commit_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DATA_W(32), .WAIT_LIMIT(8)) dut (
      .clk(clk), .rst(rst),
      .pri_we_i(pri_we_i), .pri_waddr_i(pri_waddr_i), .pri_wdata_i(pri_wdata_i),
      .sec_we_i(sec_we_i), .sec_waddr_i(sec_waddr_i), .sec_wdata_i(sec_wdata_i),
      .late_valid_i(late_valid_i), .late_waddr_i(late_waddr_i), .late_wdata_i(late_wdata_i),
      .late_ready_o(late_ready_o),
      .rf_we0_o(rf_we0_o), .rf_waddr0_o(rf_waddr0_o), .rf_wdata0_o(rf_wdata0_o),
      .rf_we1_o(rf_we1_o), .rf_waddr1_o(rf_waddr1_o), .rf_wdata1_o(rf_wdata1_o),
      .late_commit_o(late_commit_o), .stall_o(stall_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pipe(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                           input logic sw, input logic [4:0] sa, input logic [31:0] sd);
      pri_we_i = pw; pri_waddr_i = pa; pri_wdata_i = pd;
      sec_we_i = sw; sec_waddr_i = sa; sec_wdata_i = sd;
   endtask

   task automatic set_late(input logic lv, input logic [4:0] la, input logic [31:0] ld);
      late_valid_i = lv; late_waddr_i = la; late_wdata_i = ld;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_pipe(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      set_late(1'b1, 5'd3, 32'h3);
      #3;
      checks++;
      if ({rf_we0_o, rf_we1_o, late_commit_o, late_ready_o, stall_o} !== 6'b000010) begin
         failures++;
         $display("FAIL reset_hold got=%b exp=000010",
                  {rf_we0_o, rf_we1_o, late_commit_o, late_ready_o, stall_o});
      end
      checks++;
      if ({rf_waddr0_o, rf_wdata0_o} !== 37'd0) begin
         failures++;
         $display("FAIL reset_addr0 got=%h exp=0", {rf_waddr0_o, rf_wdata0_o});
      end
      step(); step();
      rst = 1'b1;
      set_pipe(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      set_late(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({rf_we0_o, rf_we1_o, late_commit_o, late_ready_o, stall_o} !== 6'b000010) begin
         failures++;
         $display("FAIL reset_release got=%b exp=000010",
                  {rf_we0_o, rf_we1_o, late_commit_o, late_ready_o, stall_o});
      end
   endtask

   task automatic test_pipeline();
      step();
      set_pipe(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
      @(negedge clk);
      checks++;
      if ({rf_we0_o, rf_we1_o, rf_waddr1_o, rf_wdata1_o} !== {1'b0, 1'b1, 5'd5, 32'h22}) begin
         failures++;
         $display("FAIL pipe_conflict got=%b/%b/%0d/%h exp=0/1/5/22",
                  rf_we0_o, rf_we1_o, rf_waddr1_o, rf_wdata1_o);
      end
      step();
      set_pipe(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
      @(negedge clk);
      checks++;
      if ({rf_we0_o, rf_waddr0_o, rf_wdata0_o, rf_we1_o, rf_waddr1_o, rf_wdata1_o} !==
          {1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66}) begin
         failures++;
         $display("FAIL pipe_dual got=%b/%0d/%h %b/%0d/%h exp=1/4/44 1/6/66",
                  rf_we0_o, rf_waddr0_o, rf_wdata0_o, rf_we1_o, rf_waddr1_o, rf_wdata1_o);
      end
      step();
      set_pipe(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({rf_we0_o, rf_waddr0_o, rf_wdata0_o} !== 38'd0) begin
         failures++;
         $display("FAIL pipe_r0 got=%b/%0d/%h exp=0/0/0", rf_we0_o, rf_waddr0_o, rf_wdata0_o);
      end
   endtask

   task automatic test_late_fill();
      step();
      set_pipe(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      set_late(1'b1, 5'd7, 32'hABCD);
      @(negedge clk);
      checks++;
      if ({rf_we0_o, rf_we1_o, late_commit_o} !== 4'b0000) begin
         failures++;
         $display("FAIL late_no_bypass got=%b exp=0000", {rf_we0_o, rf_we1_o, late_commit_o});
      end
      step();
      set_late(1'b0, 5'd0, 32'h0);
      set_pipe(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({late_commit_o, rf_we1_o, rf_waddr1_o, rf_wdata1_o, rf_we0_o, rf_waddr0_o} !==
          {2'b10, 1'b1, 5'd7, 32'hABCD, 1'b1, 5'd3}) begin
         failures++;
         $display("FAIL late_fill got=%b %b/%0d/%h p0=%b/%0d exp=10 1/7/abcd p0=1/3",
                  late_commit_o, rf_we1_o, rf_waddr1_o, rf_wdata1_o, rf_we0_o, rf_waddr0_o);
      end
      step();
      set_pipe(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({late_commit_o, rf_we0_o, rf_we1_o, late_ready_o} !== 5'b00001) begin
         failures++;
         $display("FAIL late_drained got=%b exp=00001",
                  {late_commit_o, rf_we0_o, rf_we1_o, late_ready_o});
      end
   endtask

   task automatic test_kill();
      step();
      set_pipe(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      set_late(1'b1, 5'd9, 32'h99);
      step();
      set_late(1'b0, 5'd0, 32'h0);
      set_pipe(1'b1, 5'd9, 32'h5, 1'b1, 5'd2, 32'h2);
      @(negedge clk);
      checks++;
      if ({late_commit_o, rf_waddr0_o, rf_wdata0_o} !== {2'b00, 5'd9, 32'h5}) begin
         failures++;
         $display("FAIL kill_pipe got=%b %0d/%h exp=00 9/5", late_commit_o, rf_waddr0_o, rf_wdata0_o);
      end
      step();
      set_pipe(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({late_commit_o, rf_we0_o, rf_we1_o} !== 4'b0000) begin
         failures++;
         $display("FAIL kill_popped got=%b exp=0000", {late_commit_o, rf_we0_o, rf_we1_o});
      end
      // a newer late result for the same register supersedes the buffered one
      step();
      set_pipe(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      set_late(1'b1, 5'd15, 32'h1);
      step();
      set_late(1'b1, 5'd15, 32'h2);
      step();
      set_late(1'b0, 5'd0, 32'h0);
      set_pipe(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({late_commit_o, rf_we0_o, rf_waddr0_o, rf_wdata0_o, rf_we1_o} !==
          {2'b01, 1'b1, 5'd15, 32'h2, 1'b0}) begin
         failures++;
         $display("FAIL kill_enq got=%b %b/%0d/%h we1=%b exp=01 1/15/2 we1=0",
                  late_commit_o, rf_we0_o, rf_waddr0_o, rf_wdata0_o, rf_we1_o);
      end
   endtask

   task automatic test_full();
      step();
      set_pipe(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      set_late(1'b1, 5'd10, 32'hA);
      step();
      set_late(1'b1, 5'd11, 32'hB);
      step();
      set_late(1'b1, 5'd12, 32'hC);
      @(negedge clk);
      checks++;
      if ({late_ready_o, late_commit_o} !== 3'b000) begin
         failures++;
         $display("FAIL full_ready got=%b exp=000", {late_ready_o, late_commit_o});
      end
      step();
      set_pipe(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({late_ready_o, late_commit_o, rf_waddr0_o, rf_wdata0_o, rf_waddr1_o, rf_wdata1_o} !==
          {1'b0, 2'b11, 5'd10, 32'hA, 5'd11, 32'hB}) begin
         failures++;
         $display("FAIL full_drain got=%b %b %0d/%h %0d/%h exp=0 11 10/a 11/b",
                  late_ready_o, late_commit_o, rf_waddr0_o, rf_wdata0_o, rf_waddr1_o, rf_wdata1_o);
      end
      step();
      @(negedge clk);
      checks++;
      if ({late_ready_o, late_commit_o} !== 3'b100) begin
         failures++;
         $display("FAIL full_reopen got=%b exp=100", {late_ready_o, late_commit_o});
      end
      step();
      set_late(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({late_commit_o, rf_waddr0_o, rf_wdata0_o} !== {2'b01, 5'd12, 32'hC}) begin
         failures++;
         $display("FAIL full_held got=%b %0d/%h exp=01 12/c", late_commit_o, rf_waddr0_o, rf_wdata0_o);
      end
   endtask

   task automatic test_starve();
      step();
      set_pipe(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      set_late(1'b1, 5'd13, 32'hD);
      step();
      set_late(1'b0, 5'd0, 32'h0);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         checks++;
         if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL starve_early cyc=%0d got=%b exp=0", i, stall_o);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b1) begin
         failures++;
         $display("FAIL starve_rise got=%b exp=1", stall_o);
      end
      step();
      set_pipe(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({stall_o, late_commit_o, rf_waddr1_o, rf_wdata1_o} !== {1'b1, 2'b10, 5'd13, 32'hD}) begin
         failures++;
         $display("FAIL starve_retire got=%b %b %0d/%h exp=1 10 13/d",
                  stall_o, late_commit_o, rf_waddr1_o, rf_wdata1_o);
      end
      step();
      set_pipe(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0) begin
         failures++;
         $display("FAIL starve_fall got=%b exp=0", stall_o);
      end
   endtask

   task automatic test_reset_mid();
      step();
      set_late(1'b1, 5'd14, 32'hE);
      step();
      set_late(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 10; i++) step();
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_stall_pre got=%b exp=1", stall_o);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({stall_o, late_ready_o, rf_we0_o, rf_we1_o, late_commit_o} !== 6'b010000) begin
         failures++;
         $display("FAIL mid_reset got=%b exp=010000",
                  {stall_o, late_ready_o, rf_we0_o, rf_we1_o, late_commit_o});
      end
      step();
      rst = 1'b1;
      set_pipe(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if ({late_commit_o, rf_we0_o, rf_we1_o, stall_o} !== 5'b00000) begin
         failures++;
         $display("FAIL mid_reset_empty got=%b exp=00000",
                  {late_commit_o, rf_we0_o, rf_we1_o, stall_o});
      end
   endtask

   initial begin
      test_reset();
      test_pipeline();
      test_late_fill();
      test_kill();
      test_full();
      test_starve();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
